// File: rtl/tick_divider_pkg.sv
// Shared constants and helpers for the tick_divider block.
package tick_divider_pkg;

    localparam int unsigned ClkHz         = 50_000_000;
    localparam int unsigned TickHzDefault = 100;
    localparam int unsigned DefaultDiv    = ClkHz / TickHzDefault;

    // Helpers work at a fixed width; callers cast to/from their own WIDTH (<= MaxWidth).
    localparam int unsigned MaxWidth = 32;

    function automatic logic [MaxWidth-1:0] clamp_div(input logic [MaxWidth-1:0] n);
        return (n == '0) ? MaxWidth'(1) : n;
    endfunction

    // ceil(n/2) without the n+1 overflow at the top of the range.
    function automatic logic [MaxWidth-1:0] half_period(input logic [MaxWidth-1:0] n);
        return (n >> 1) + {{(MaxWidth-1){1'b0}}, n[0]};
    endfunction

endpackage

// File: rtl/tick_divider_shadow.sv
// Pending-divisor register with valid/ready intake; releases the value when apply_i is seen.
module tick_divider_shadow import tick_divider_pkg::*; #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             div_valid_i,
    input  logic [WIDTH-1:0] div_in_i,
    input  logic             apply_i,
    output logic             div_ready_o,
    output logic             load_o,
    output logic [WIDTH-1:0] pend_div_o
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ready_q, ready_d;
    logic             accept;

    // ready_q doubles as the "pending register empty" flag.
    assign accept = div_valid_i & ready_q;
    assign load_o = apply_i & ~ready_q;

    always_comb begin
        pend_d  = pend_q;
        ready_d = ready_q;
        if (accept) begin
            pend_d  = WIDTH'(clamp_div(MaxWidth'(div_in_i)));
            ready_d = 1'b0;
        end else if (load_o) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            ready_q <= ready_d;
        end
    end

    assign div_ready_o = ready_q;
    assign pend_div_o  = pend_q;

endmodule

// File: rtl/tick_divider.sv
// Programmable tick generator: one-cycle enable every div_cur cycles, optional square output.
// Square output is built only when TICK_DIVIDER_SQ_EN is defined; otherwise sq is tied to 0.
module tick_divider import tick_divider_pkg::*; #(
    parameter int unsigned WIDTH       = 19,
    parameter int unsigned DEFAULT_DIV = tick_divider_pkg::DefaultDiv
) (
    input  logic             CLK_50_MHz,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic             sq,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(clamp_div(MaxWidth'(DEFAULT_DIV)));

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;
    logic             load;
    logic [WIDTH-1:0] pend_div;

    assign wrap  = en & ~sync & (count_q == (div_cur_q - WIDTH'(1)));
    assign apply = wrap | sync | ~en;

    tick_divider_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk_i       (CLK_50_MHz),
        .rst_ni      (reset_n),
        .div_valid_i (div_valid),
        .div_in_i    (div_in),
        .apply_i     (apply),
        .div_ready_o (div_ready),
        .load_o      (load),
        .pend_div_o  (pend_div)
    );

    always_comb begin
        count_d   = count_q;
        tick_d    = 1'b0;
        div_cur_d = div_cur_q;
        if (sync) begin
            count_d = '0;
        end else if (en) begin
            if (wrap) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        // A shrinking divisor loaded while paused must not leave count outside 0..N-1.
        if (load) begin
            div_cur_d = pend_div;
            if (count_q >= (pend_div - WIDTH'(1))) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            div_cur_q <= ResetDiv;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            div_cur_q <= div_cur_d;
            tick_q    <= tick_d;
        end
    end

`ifdef TICK_DIVIDER_SQ_EN
    logic sq_q, sq_d;

    assign sq_d = (count_d < WIDTH'(half_period(MaxWidth'(div_cur_d))));

    always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
        if (!reset_n) begin
            sq_q <= 1'b1;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

    assign count   = count_q;
    assign div_cur = div_cur_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_tick_divider.sv
// Self-checking bench for tick_divider: literal vector table, corner sequences, random vs model.
module tb_tick_divider;

    localparam int W   = 8;
    localparam int DEF = 5;
`ifdef TICK_DIVIDER_SQ_EN
    localparam bit SqOn = 1'b1;
`else
    localparam bit SqOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sync;
    logic [W-1:0] div_in;
    logic         div_valid;
    logic         div_ready;
    logic         tick;
    logic         sq;
    logic [W-1:0] count;
    logic [W-1:0] div_cur;

    always #5 clk = ~clk;

    tick_divider #(
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .CLK_50_MHz (clk),
        .reset_n    (rst_n),
        .en         (en),
        .sync       (sync),
        .div_in     (div_in),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .tick       (tick),
        .sq         (sq),
        .count      (count),
        .div_cur    (div_cur)
    );

    int n_tests;
    int n_fail;

    // Reference state: what the outputs should read right now.
    int m_count;
    int m_div;
    bit m_tick;
    bit m_ready;
    int m_pend[$];

    typedef struct {
        bit en;
        bit sync;
        bit valid;
        int din;
        int cnt;
        bit tk;
        int dv;
        bit rdy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_div   = DEF;
        m_tick  = 1'b0;
        m_ready = 1'b1;
        m_pend.delete();
    endtask

    task automatic model_step(input bit e, input bit s, input bit v, input int d);
        bit wrap;
        int nc;
        int nd;
        bit nr;
        wrap = e && !s && (m_count == m_div - 1);
        if (s)      nc = 0;
        else if (e) nc = wrap ? 0 : m_count + 1;
        else        nc = m_count;
        nd = m_div;
        nr = m_ready;
        if ((wrap || s || !e) && m_pend.size() > 0) begin
            nd = m_pend.pop_front();
            nr = 1'b1;
            if (m_count >= nd - 1) nc = 0;
        end
        if (v && m_ready) begin
            m_pend.push_back(d == 0 ? 1 : d);
            nr = 1'b0;
        end
        m_count = nc;
        m_div   = nd;
        m_tick  = wrap;
        m_ready = nr;
    endtask

    task automatic check_model(input string tag);
        int exp_sq;
        exp_sq = SqOn ? int'(m_count < (m_div + 1) / 2) : 0;
        chk({tag, " count"}, int'(count), m_count);
        chk({tag, " tick"}, int'(tick), int'(m_tick));
        chk({tag, " div_cur"}, int'(div_cur), m_div);
        chk({tag, " div_ready"}, int'(div_ready), int'(m_ready));
        chk({tag, " sq"}, int'(sq), exp_sq);
    endtask

    task automatic step(input bit e, input bit s, input bit v, input int d);
        en        = e;
        sync      = s;
        div_valid = v;
        div_in    = W'(d);
        @(posedge clk);
        model_step(e, s, v, d & 255);
        #1;
    endtask

    task automatic set_div(input int n);
        step(1'b0, 1'b0, 1'b1, n);
        check_model("set_div accept");
        step(1'b0, 1'b0, 1'b0, 0);
        check_model("set_div apply");
        step(1'b0, 1'b1, 1'b0, 0);
        check_model("set_div sync");
    endtask

    task automatic measure(input string name, input int expn);
        int k;
        int got;
        got = -1;
        for (k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            check_model(name);
            if (tick) begin
                got = k;
                break;
            end
        end
        chk({name, " period"}, got, expn);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Starts from count 0, div 5, ready 1.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 5, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 5, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 5, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 0, 4, 1'b0, 5, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3, 1, 1'b0, 5, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 5, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 0, 4, 1'b0, 5, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 3, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 3, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 3, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 3, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 3, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 3, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 3, 1'b1};

        en        = 1'b0;
        sync      = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Default divisor 5: ticks on enabled edges 5, 10, 15.
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            check_model($sformatf("def%0d", i));
            chk($sformatf("def%0d tick literal", i), int'(tick), int'(i % 5 == 0));
            chk($sformatf("def%0d sq literal", i), int'(sq), SqOn ? int'((i % 5) < 3) : 0);
        end

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].en, vecs[i].sync, vecs[i].valid, vecs[i].din);
            check_model($sformatf("vec%0d model", i));
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].tk));
            chk($sformatf("vec%0d div_cur", i), int'(div_cur), vecs[i].dv);
            chk($sformatf("vec%0d div_ready", i), int'(div_ready), int'(vecs[i].rdy));
        end

        // N=4, request 7 while count=1: current 4-period completes first.
        set_div(4);
        step(1'b1, 1'b0, 1'b0, 0);
        check_model("A pre");
        step(1'b1, 1'b0, 1'b1, 7);
        check_model("A accept");
        chk("A ready after accept", int'(div_ready), 0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("A ready held", int'(div_ready), 0);
        chk("A old div held", int'(div_cur), 4);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("A wrap tick", int'(tick), 1);
        chk("A wrap div", int'(div_cur), 7);
        chk("A wrap ready", int'(div_ready), 1);
        measure("A p1", 7);
        measure("A p2", 7);

        // Divisor 0 clamps to 1.
        set_div(0);
        chk("B div_cur", int'(div_cur), 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            check_model("B run");
            chk("B tick", int'(tick), 1);
            chk("B count", int'(count), 0);
            chk("B sq", int'(sq), SqOn ? 1 : 0);
        end

        // Sync on the wrap edge suppresses the tick.
        set_div(6);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0);
        chk("C pre count", int'(count), 5);
        step(1'b1, 1'b1, 1'b0, 0);
        check_model("C sync");
        chk("C sync tick", int'(tick), 0);
        chk("C sync count", int'(count), 0);
        measure("C next", 6);

        // N=3, en low for 10 cycles at count=2.
        set_div(3);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("D pre count", int'(count), 2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 0);
            chk("D hold count", int'(count), 2);
            chk("D hold tick", int'(tick), 0);
        end
        step(1'b1, 1'b0, 1'b0, 0);
        chk("D resume tick", int'(tick), 1);
        chk("D resume count", int'(count), 0);

        // Shrink while paused with count beyond new range.
        set_div(6);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 3);
        chk("E accept count", int'(count), 4);
        step(1'b0, 1'b0, 1'b0, 0);
        check_model("E apply");
        chk("E apply count", int'(count), 0);
        chk("E apply div", int'(div_cur), 3);

        // Reset mid-period discards a pending divisor.
        set_div(7);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("G reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        measure("G first", DEF);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit s;
            bit v;
            int d;
            e = ($urandom_range(0, 9) < 8);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 9));
            step(e, s, v, d);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
